apbuart_rx: RTL and testbench
=============================

# apbuart_rx

Receive engine for the APB UART: samples the asynchronous `rxd` line at 8x the bit rate and reassembles 8N1/8E1/8O1 frames into a one-entry holding register. It is instantiated inside the APB UART wrapper, which owns register decode. The wrapper maps `rx_data` onto UART0_DATA, maps the flags onto UART0_STATUS bits DR[0], BR[3], OV[4], PE[5], FE[6], and drives the enables from UART0_CTRL and the divider from UART0_SCALER.

## Interface
- `SCALER_W`, default 12: width of the baud divider input.
- `clk` input 1: system clock (50 MHz nominal).
- `rst` input 1: system reset, asynchronous, active-high.
- `scaler` input SCALER_W: tick period minus 1. One tick occurs every `scaler`+1 clocks, and a bit lasts 8 ticks. A value of 53 gives 115200 baud at 50 MHz.
- `rx_en` input 1: receiver enable (CTRL RE).
- `ri_en` input 1: receive interrupt enable (CTRL RI).
- `par_en` input 1: parity bit present (CTRL PE).
- `par_odd` input 1: 1 selects odd parity, 0 selects even (CTRL PS).
- `rxd` input 1: serial input, asynchronous, idle high.
- `rd_strobe` input 1: one-clock pulse on an APB read of UART0_DATA.
- `clr_err` input 1: one-clock pulse on an APB write to UART0_STATUS. It clears BR, OV, PE and FE.
- `rx_data` output 8: holding register.
- `dr` output 1: data ready.
- `br` output 1: break received.
- `ov` output 1: overrun.
- `pe` output 1: parity error.
- `fe` output 1: framing error.
- `rx_irq` output 1: one-clock pulse when a frame is loaded while `ri_en`=1.

## Operation
- **Input sync.** `rxd` passes through a 2-flop synchronizer, reset to 1.
- **Tick generator.** A down-counter reloads `scaler` when it reaches 0 and emits `tick` in that cycle. It free-runs whenever `rx_en`=1 and is held at `scaler` while `rx_en`=0.
- **FSM states.** IDLE, START, DATA, PARITY, STOP, BRKWAIT. A 3-bit sub-counter `phase` counts ticks within a bit, and a 3-bit `bitcnt` counts data bits.
- **IDLE.** On a tick where the synced `rxd`=0, go to START with `phase`=0.
- **START.** At `phase`=3, if synced `rxd`=1 the start is false and the FSM returns to IDLE. Otherwise continue, and at `phase`=7 go to DATA.
- **Bit sampling.** Every data, parity and stop bit takes the majority of the samples at `phase` 3, 4 and 5. The bit is resolved at `phase`=7.
- **DATA.** Bits are captured LSB first into a shift register. After 8 bits, go to PARITY if `par_en`=1, otherwise to STOP.
- **PARITY.** The error condition is the XOR of the received bit, the 8 data bits and `par_odd`.
- **STOP, evaluated at `phase`=5 (mid-stop, no waiting for the end of the bit):**
  - **Break.** If all data bits, the parity bit (when present) and the stop bit are 0: set `br`, do not load, do not touch `dr`, go to BRKWAIT.
  - **Otherwise, load:** `rx_data` takes the shift register, `dr` is set to 1, and `fe` is set to 1 if the stop bit is 0. `pe` is set to 1 on a parity error. Go to IDLE.
- **Overrun.** If a load occurs while `dr`=1 and `rd_strobe`=0, the new byte is dropped, `rx_data` is kept, `ov` is set to 1, and `fe` and `pe` are still updated.
- **BRKWAIT.** Returns to IDLE on the first tick where the synced `rxd`=1.
- **Flag clearing.** `rd_strobe` clears `dr`. `clr_err` clears `br`, `ov`, `pe` and `fe`.
- **Simultaneous events.**
  - A load and `rd_strobe` in the same cycle: the load wins, `dr` stays 1, and `ov` is not set.
  - A set and `clr_err` in the same cycle: the set wins.
- **Disable.** Dropping `rx_en` sends the FSM to IDLE on the next clock. The partial frame is discarded, and flags and `rx_data` are retained.
- **Reset.** Asserting `rst` mid-frame returns everything to reset values immediately.

## Timing
- **Reset values:** `rx_data`=0x00; `dr`, `br`, `ov`, `pe`, `fe` and `rx_irq` all 0; FSM in IDLE; synchronizer flops at 1.
- **Load latency.** `dr`, `rx_data` and `rx_irq` update on the clock edge of the mid-stop tick. For 8N1 that is 9 bits + 5 ticks = 77 ticks after start detection, ±1 tick of detection jitter plus 2 synchronizer clocks. With `scaler`=53, that is 77×54 = 4158 clocks.
- **Pulse and flag widths.** `rx_irq` is exactly one clock wide. All flags are registered outputs.

## Structure
- **Shared package `apbuart_pkg`:** the FSM state enum; the UART0_CTRL bit indices (RE=0, TE=1, RI=2, TI=3, PS=4, PE=5, LB=7); the UART0_STATUS bit indices (DR=0, TS=1, TE=2, BR=3, OV=4, PE=5, FE=6).
- **Sub-module `apbuart_baud_tick`:** the tick prescaler, reused by the transmitter.

## Test plan
- **Basic receive.** `scaler`=53, RE=1, 8N1 frame 0x55 on `rxd` -> `dr`=1 and `rx_data`=0x55 about 4158 clocks after the falling edge, no error flags. `rd_strobe` -> `dr`=0.
- **Overrun.** Two frames 0x55 then 0x66 with no read -> `ov`=1, `rx_data`=0x55, `dr`=1. `clr_err` -> `ov`=0.
- **Parity and framing.** `par_en`=1, even parity: 0x07 with parity bit 0 -> `pe`=1, `rx_data`=0x07. Separately, 0xA5 with stop bit 0 -> `fe`=1 and `dr`=1.
- **Glitch and break.** A low pulse of 2 ticks -> no frame and FSM back in IDLE. `rxd` held low for 12 bit times -> `br`=1, `dr`=0. After `rxd` returns high, 0x3C is received normally.
- **Simultaneous read and load.** `rd_strobe` in the same cycle as a load -> `dr` stays 1, `ov`=0. `clr_err` coinciding with an FE set -> `fe`=1.
- **Disable and reset mid-frame.** `rst` asserted mid-frame of 0x81 -> all outputs 0, then the next 0x81 is received correctly. `rx_en` dropped mid-frame -> no load, flags unchanged.

Source files
------------

// File: rtl/apbuart_pkg.sv
// Shared definitions for the APB UART: receiver FSM state encoding, UART0_CTRL and
// UART0_STATUS bit positions, and a 3-input majority helper used for bit sampling.
package apbuart_pkg;

  // Receiver FSM states (plain constants kept for compatibility with older code)
  typedef logic [2:0] rx_state_t;
  localparam rx_state_t StIdle    = 3'd0;
  localparam rx_state_t StStart   = 3'd1;
  localparam rx_state_t StData    = 3'd2;
  localparam rx_state_t StParity  = 3'd3;
  localparam rx_state_t StStop    = 3'd4;
  localparam rx_state_t StBrkWait = 3'd5;

  // UART0_CTRL bit indices
  localparam int unsigned CtrlRe = 0;
  localparam int unsigned CtrlTe = 1;
  localparam int unsigned CtrlRi = 2;
  localparam int unsigned CtrlTi = 3;
  localparam int unsigned CtrlPs = 4;
  localparam int unsigned CtrlPe = 5;
  localparam int unsigned CtrlLb = 7;

  // UART0_STATUS bit indices
  localparam int unsigned StatDr = 0;
  localparam int unsigned StatTs = 1;
  localparam int unsigned StatTe = 2;
  localparam int unsigned StatBr = 3;
  localparam int unsigned StatOv = 4;
  localparam int unsigned StatPe = 5;
  localparam int unsigned StatFe = 6;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/apbuart_baud_tick.sv
// Baud prescaler shared by the UART receiver and transmitter. A down-counter reloads
// `scaler` when it reaches zero and emits `tick` in that cycle, so one tick occurs
// every scaler+1 clocks. While disabled the counter is held at `scaler`.
//   clk, rst : clock, asynchronous active-high reset
//   en       : counter runs when 1
//   scaler   : tick period minus one
//   tick     : one-clock pulse per tick period
module apbuart_baud_tick
  import apbuart_pkg::*;
#(
  parameter int unsigned SCALER_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SCALER_W-1:0] scaler,
  output logic                tick
);

  logic [SCALER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en || (cnt_q == '0)) begin
      cnt_d = scaler;
    end else begin
      cnt_d = cnt_q - SCALER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/apbuart_rx.sv
// APB UART receive engine. Oversamples the asynchronous rxd line at 8 ticks per bit,
// reassembles 8N1/8E1/8O1 frames and loads them into a one-entry holding register
// with data-ready, break, overrun, parity-error and framing-error flags.
//   clk, rst      : clock, asynchronous active-high reset
//   scaler        : tick period minus one (bit = 8 ticks)
//   rx_en, ri_en  : receiver enable, receive interrupt enable
//   par_en        : parity bit present; par_odd selects odd parity
//   rxd           : serial input, idle high
//   rd_strobe     : data register read (clears dr)
//   clr_err       : status write (clears br, ov, pe, fe)
//   rx_data       : holding register
//   dr/br/ov/pe/fe: status flags
//   rx_irq        : one-clock pulse on a load while ri_en=1
module apbuart_rx
  import apbuart_pkg::*;
#(
  parameter int unsigned SCALER_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SCALER_W-1:0] scaler,
  input  logic                rx_en,
  input  logic                ri_en,
  input  logic                par_en,
  input  logic                par_odd,
  input  logic                rxd,
  input  logic                rd_strobe,
  input  logic                clr_err,
  output logic [7:0]          rx_data,
  output logic                dr,
  output logic                br,
  output logic                ov,
  output logic                pe,
  output logic                fe,
  output logic                rx_irq
);

  logic tick;

  apbuart_baud_tick #(
    .SCALER_W(SCALER_W)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (rx_en),
    .scaler(scaler),
    .tick  (tick)
  );

  logic      rxd_meta_q, rxd_sync_q;
  rx_state_t state_q, state_d;
  logic [2:0] phase_q, phase_d, bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic      s3_q, s3_d, s4_q, s4_d, bit_q, bit_d;
  logic      has_par_q, has_par_d, par_bit_q, par_bit_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic      dr_q, dr_d, br_q, br_d, ov_q, ov_d, pe_q, pe_d, fe_q, fe_d, irq_q, irq_d;

  logic [2:0] cur_phase;
  logic      samp_maj, frame_done, brk_det, par_err, load_ok, overrun;

  // phase_q holds the phase of the last processed tick; the detection tick is phase 0
  assign cur_phase = phase_q + 3'd1;
  assign samp_maj  = maj3(s3_q, s4_q, rxd_sync_q);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    s3_d       = s3_q;
    s4_d       = s4_q;
    bit_d      = bit_q;
    has_par_d  = has_par_q;
    par_bit_d  = par_bit_q;
    frame_done = 1'b0;
    brk_det    = 1'b0;

    if (!rx_en) begin
      state_d = StIdle;
      phase_d = 3'd0;
    end else if (tick) begin
      if ((state_q != StIdle) && (state_q != StBrkWait)) begin
        phase_d = cur_phase;
        if (cur_phase == 3'd3) s3_d = rxd_sync_q;
        if (cur_phase == 3'd4) s4_d = rxd_sync_q;
        if (cur_phase == 3'd5) bit_d = samp_maj;
      end

      case (state_q)
        StIdle: begin
          if (!rxd_sync_q) begin
            state_d  = StStart;
            phase_d  = 3'd0;
            bitcnt_d = 3'd0;
          end
        end
        StStart: begin
          if ((cur_phase == 3'd3) && rxd_sync_q) begin
            state_d = StIdle;
          end else if (cur_phase == 3'd7) begin
            state_d = StData;
          end
        end
        StData: begin
          if (cur_phase == 3'd7) begin
            shift_d  = {bit_q, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              has_par_d = par_en;
              state_d   = par_en ? StParity : StStop;
            end
          end
        end
        StParity: begin
          if (cur_phase == 3'd7) begin
            par_bit_d = bit_q;
            state_d   = StStop;
          end
        end
        StStop: begin
          // Decided mid-stop so a back-to-back start edge is never missed
          if (cur_phase == 3'd5) begin
            if ((shift_q == '0) && !(has_par_q && par_bit_q) && !samp_maj) begin
              brk_det = 1'b1;
              state_d = StBrkWait;
            end else begin
              frame_done = 1'b1;
              state_d    = StIdle;
            end
          end
        end
        StBrkWait: begin
          if (rxd_sync_q) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign par_err = has_par_q && (par_bit_q ^ (^shift_q) ^ par_odd);
  assign overrun = frame_done && dr_q && !rd_strobe;
  assign load_ok = frame_done && !overrun;

  // Set terms take priority over the clear strobes
  always_comb begin
    rx_data_d = load_ok ? shift_q : rx_data_q;
    dr_d      = load_ok ? 1'b1 : (rd_strobe ? 1'b0 : dr_q);
    br_d      = brk_det ? 1'b1 : (clr_err ? 1'b0 : br_q);
    ov_d      = overrun ? 1'b1 : (clr_err ? 1'b0 : ov_q);
    pe_d      = (frame_done && par_err) ? 1'b1 : (clr_err ? 1'b0 : pe_q);
    fe_d      = (frame_done && !samp_maj) ? 1'b1 : (clr_err ? 1'b0 : fe_q);
    irq_d     = load_ok && ri_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      state_q    <= StIdle;
      phase_q    <= 3'd0;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'h00;
      s3_q       <= 1'b1;
      s4_q       <= 1'b1;
      bit_q      <= 1'b1;
      has_par_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      rx_data_q  <= 8'h00;
      dr_q       <= 1'b0;
      br_q       <= 1'b0;
      ov_q       <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      state_q    <= state_d;
      phase_q    <= phase_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      s3_q       <= s3_d;
      s4_q       <= s4_d;
      bit_q      <= bit_d;
      has_par_q  <= has_par_d;
      par_bit_q  <= par_bit_d;
      rx_data_q  <= rx_data_d;
      dr_q       <= dr_d;
      br_q       <= br_d;
      ov_q       <= ov_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      irq_q      <= irq_d;
    end
  end

  assign rx_data = rx_data_q;
  assign dr      = dr_q;
  assign br      = br_q;
  assign ov      = ov_q;
  assign pe      = pe_q;
  assign fe      = fe_q;
  assign rx_irq  = irq_q;

endmodule

// File: tb/tb_apbuart_rx.sv
// Self-checking bench for apbuart_rx: directed scenarios plus randomized frames whose
// expected byte and error flags are pushed to a scoreboard and checked on rx_irq.
module tb_apbuart_rx;

  localparam int unsigned SW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] scaler;
  logic          rx_en, ri_en, par_en, par_odd, rxd, rd_strobe, clr_err;
  logic [7:0]    rx_data;
  logic          dr, br, ov, pe, fe, rx_irq;

  always #5 clk = ~clk;

  apbuart_rx #(
    .SCALER_W(SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scaler   (scaler),
    .rx_en    (rx_en),
    .ri_en    (ri_en),
    .par_en   (par_en),
    .par_odd  (par_odd),
    .rxd      (rxd),
    .rd_strobe(rd_strobe),
    .clr_err  (clr_err),
    .rx_data  (rx_data),
    .dr       (dr),
    .br       (br),
    .ov       (ov),
    .pe       (pe),
    .fe       (fe),
    .rx_irq   (rx_irq)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_bclk = 432;
  logic irq_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    step(cur_bclk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit with_par, input bit parbit,
                            input bit stopbit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (with_par) send_bit(parbit);
    send_bit(stopbit);
    rxd = 1'b1;
  endtask

  task automatic idle(input int bits);
    step(bits * cur_bclk);
  endtask

  task automatic set_cfg(input int s, input bit pen, input bit podd);
    rx_en = 1'b0;
    step(1);
    scaler   = SW'(s);
    par_en   = pen;
    par_odd  = podd;
    cur_bclk = 8 * (s + 1);
    rx_en    = 1'b1;
    step(cur_bclk);
  endtask

  task automatic clear_all();
    rd_strobe = 1'b1;
    clr_err   = 1'b1;
    step(1);
    rd_strobe = 1'b0;
    clr_err   = 1'b0;
  endtask

  // Parity bit a correct transmitter would send for this byte
  function automatic bit good_parity(input logic [7:0] d, input bit podd);
    bit ones_even;
    ones_even = ($countones(d) % 2) == 0;
    return podd ? ones_even : !ones_even;
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic p, input logic f);
    exp_t e;
    e.data = d;
    e.pe   = p;
    e.fe   = f;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: every load pulse must match the oldest expected frame
  always @(negedge clk) begin
    if (rst) begin
      irq_prev = 1'b0;
    end else begin
      if (irq_prev) check("irq_width", rx_irq, 0);
      if (rx_irq) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_irq: got rx_data 0x%0h, required no load", rx_data);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_data", rx_data, mon_e.data);
          check("sb_pe", pe, mon_e.pe);
          check("sb_fe", fe, mon_e.fe);
          check("sb_dr", dr, 1);
        end
      end
      irq_prev = rx_irq;
    end
  end

  initial begin
    logic [7:0] d;
    bit         pen, podd, pb, corr, sb;
    int         s, lat;

    rst = 1'b1; rxd = 1'b1; rx_en = 1'b0; ri_en = 1'b0; par_en = 1'b0; par_odd = 1'b0;
    rd_strobe = 1'b0; clr_err = 1'b0; scaler = SW'(53);
    step(3);
    check("rst_data", rx_data, 8'h00);
    check("rst_dr", dr, 0);
    check("rst_br", br, 0);
    check("rst_ov", ov, 0);
    check("rst_pe_fe", {pe, fe}, 0);
    check("rst_irq", rx_irq, 0);
    rst = 1'b0;
    step(1);

    // Basic 8N1 receive at scaler 53, with load latency measured from the falling edge
    set_cfg(53, 0, 0);
    lat = 0;
    fork
      send_frame(8'h55, 0, 0, 1);
      begin
        while (!dr && lat < 6000) begin
          step(1);
          lat++;
        end
      end
    join
    check("basic_latency_window", (lat >= 4158 - 54) && (lat <= 4158 + 57), 1);
    check("basic_dr", dr, 1);
    check("basic_data", rx_data, 8'h55);
    check("basic_no_err", {br, ov, pe, fe}, 0);
    rd_strobe = 1'b1; step(1); rd_strobe = 1'b0;
    check("basic_read_clears_dr", dr, 0);

    // Overrun
    set_cfg(7, 0, 0);
    send_frame(8'h55, 0, 0, 1); idle(2);
    send_frame(8'h66, 0, 0, 1); idle(2);
    check("ovr_ov", ov, 1);
    check("ovr_data_kept", rx_data, 8'h55);
    check("ovr_dr", dr, 1);
    clr_err = 1'b1; step(1); clr_err = 1'b0;
    check("ovr_clr", ov, 0);
    clear_all();

    // Even parity error and framing error
    set_cfg(7, 1, 0);
    send_frame(8'h07, 1, 0, 1); idle(2);
    check("par_pe", pe, 1);
    check("par_data", rx_data, 8'h07);
    check("par_no_fe", fe, 0);
    clear_all();
    set_cfg(7, 0, 0);
    send_frame(8'hA5, 0, 0, 0); idle(2);
    check("frm_fe", fe, 1);
    check("frm_dr", dr, 1);
    check("frm_data", rx_data, 8'hA5);
    clear_all();

    // Glitch of two ticks, then a 12-bit-time break, then normal reception
    rxd = 1'b0; step(2 * 8); rxd = 1'b1;
    idle(3);
    check("glitch_no_frame", {dr, br, fe}, 0);
    rxd = 1'b0; step(12 * cur_bclk);
    check("brk_br", br, 1);
    check("brk_dr", dr, 0);
    rxd = 1'b1; idle(2);
    send_frame(8'h3C, 0, 0, 1); idle(2);
    check("post_brk_dr", dr, 1);
    check("post_brk_data", rx_data, 8'h3C);
    clear_all();

    // Exact-cycle events at scaler 0: the load lands on the 80th edge after rxd falls
    set_cfg(0, 0, 0);
    ri_en = 1'b1;
    push_exp(8'h11, 0, 0);
    send_frame(8'h11, 0, 0, 1); idle(2);
    push_exp(8'h22, 0, 0);
    fork
      send_frame(8'h22, 0, 0, 1);
      begin
        step(79); rd_strobe = 1'b1; step(1); rd_strobe = 1'b0;
        @(negedge clk);
        check("rd_load_dr", dr, 1);
        check("rd_load_ov", ov, 0);
      end
    join
    idle(2);
    rd_strobe = 1'b1; step(1); rd_strobe = 1'b0;
    push_exp(8'h33, 0, 1);
    fork
      send_frame(8'h33, 0, 0, 0);
      begin
        step(79); clr_err = 1'b1; step(1); clr_err = 1'b0;
        @(negedge clk);
        check("clr_fe_set_wins", fe, 1);
      end
    join
    idle(2);
    clear_all();
    ri_en = 1'b0;

    // Reset in the middle of a frame, with flags set beforehand
    set_cfg(7, 0, 0);
    send_frame(8'hA5, 0, 0, 0); idle(2);
    d = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rst = 1'b1; step(2);
    check("midrst_data", rx_data, 8'h00);
    check("midrst_flags", {dr, br, ov, pe, fe, rx_irq}, 0);
    rxd = 1'b1; step(2 * cur_bclk);
    rst = 1'b0;
    set_cfg(7, 0, 0);
    send_frame(8'h81, 0, 0, 1); idle(2);
    check("post_rst_dr", dr, 1);
    check("post_rst_data", rx_data, 8'h81);

    // Drop rx_en mid-frame: the partial frame is discarded, flags retained
    d = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx_en = 1'b0;
    for (int i = 4; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    step(cur_bclk);
    rx_en = 1'b1;
    idle(2);
    check("dis_dr_kept", dr, 1);
    check("dis_data_kept", rx_data, 8'h81);
    check("dis_no_ov_fe", {ov, fe}, 0);
    clear_all();

    // Randomized frames against the scoreboard
    ri_en = 1'b1;
    for (int n = 0; n < 24; n++) begin
      s    = int'($urandom_range(0, 4));
      pen  = bit'($urandom_range(0, 1));
      podd = bit'($urandom_range(0, 1));
      set_cfg(s, pen, podd);
      d    = 8'($urandom);
      corr = good_parity(d, podd);
      pb   = ($urandom_range(0, 3) == 0) ? !corr : corr;
      sb   = ($urandom_range(0, 5) != 0);
      if (!sb && d == 8'h00 && (!pen || !pb)) sb = 1'b1;  // avoid a break pattern
      push_exp(d, pen && (pb != corr), !sb);
      send_frame(d, pen, pb, sb);
      idle(2);
      clear_all();
    end

    for (int i = 0; i < 1000 && sb_q.size() != 0; i++) step(1);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
